// File: rtl/cpu_supervisor_pkg.sv
// Shared definitions for the csm core supervisor:
// state encodings and verdict bit positions for LED mapping.
package cpu_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int V_DONE    = 0;
    localparam int V_PASSED  = 1;
    localparam int V_TIMEOUT = 2;

endpackage

// File: rtl/cpu_supervisor_sat.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
// o_max flags the all-ones value where counting stops.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_max
);

    assign o_max = &o_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_en && !o_max) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_supervisor.sv
// Start-up sequencer, watchdog and verdict latch for the csm core.
// Every output decodes from registers, never from inputs directly.
module cpu_supervisor
    import cpu_supervisor_pkg::*;
#(
    parameter int INIT_DELAY = 3,
    parameter int TIMEOUT    = 0,
    parameter int CNT_W      = 24,
    parameter int AUTO_START = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_running,
    input  logic             i_status,
    output logic             o_run,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_passed,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycles
);

    localparam int DW = (INIT_DELAY > 0) ? $clog2(INIT_DELAY + 1) : 1;
    localparam logic [DW-1:0] DLY_INIT = DW'(INIT_DELAY);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    state_t           state_n;
    logic [DW-1:0]    delay;
    logic [DW-1:0]    delay_n;
    logic [2:0]       verdict;
    logic [2:0]       verdict_n;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_max;
    logic [CNT_W-1:0] cycles;
    logic             busy;
    logic             halt;
    logic             wd_hit;

    sat_counter #(.W(CNT_W)) u_cycles (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (cnt_clr),
        .i_en    (cnt_en),
        .o_count (cycles),
        .o_max   (cnt_max)
    );

    assign busy   = (state == ST_START) || (state == ST_RUN);
    assign halt   = (state == ST_RUN) && !i_running;
    assign wd_hit = (TIMEOUT != 0) && busy && (cycles == TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_INIT;
            delay   <= DLY_INIT;
            verdict <= '0;
        end else begin
            state   <= state_n;
            delay   <= delay_n;
            verdict <= verdict_n;
        end
    end

    always_comb begin
        state_n   = state;
        delay_n   = delay;
        verdict_n = verdict;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_INIT: begin
                if (delay == '0) begin
                    state_n = (AUTO_START != 0) ? ST_START : ST_IDLE;
                end else begin
                    delay_n = delay - 1'b1;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_n   = ST_START;
                    cnt_clr   = 1'b1;
                    verdict_n = '0;
                end
            end
            ST_START: begin
                if (wd_hit) begin
                    state_n              = ST_DONE;
                    verdict_n            = '0;
                    verdict_n[V_DONE]    = 1'b1;
                    verdict_n[V_TIMEOUT] = 1'b1;
                end else begin
                    cnt_en = !cnt_max;
                    if (i_running) state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                // A halt on the watchdog edge still reports the core's status
                if (halt) begin
                    state_n             = ST_DONE;
                    verdict_n           = '0;
                    verdict_n[V_DONE]   = 1'b1;
                    verdict_n[V_PASSED] = i_status;
                end else if (wd_hit) begin
                    state_n              = ST_DONE;
                    verdict_n            = '0;
                    verdict_n[V_DONE]    = 1'b1;
                    verdict_n[V_TIMEOUT] = 1'b1;
                end else begin
                    cnt_en = !cnt_max;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign o_run     = busy;
    assign o_busy    = busy;
    assign o_done    = verdict[V_DONE];
    assign o_passed  = verdict[V_PASSED];
    assign o_timeout = verdict[V_TIMEOUT];
    assign o_cycles  = cycles;

endmodule

// File: tb/tb_cpu_supervisor.sv
// Scoreboard bench: two supervisors (auto-start with watchdog,
// manual-start with a 4-bit counter) driven by directed core behaviour.
module tb_cpu_supervisor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_start, a_running, a_status;
    logic        b_start, b_running, b_status;
    logic        a_run, a_busy, a_done, a_passed, a_timeout;
    logic        b_run, b_busy, b_done, b_passed, b_timeout;
    logic [23:0] a_cycles;
    logic [3:0]  b_cycles;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string name;
        logic  passed;
        logic  timeout;
        int    cycles;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    cpu_supervisor #(
        .INIT_DELAY(3), .TIMEOUT(20), .CNT_W(24), .AUTO_START(1)
    ) dut_a (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (a_start),
        .i_running (a_running),
        .i_status  (a_status),
        .o_run     (a_run),
        .o_busy    (a_busy),
        .o_done    (a_done),
        .o_passed  (a_passed),
        .o_timeout (a_timeout),
        .o_cycles  (a_cycles)
    );

    cpu_supervisor #(
        .INIT_DELAY(3), .TIMEOUT(0), .CNT_W(4), .AUTO_START(0)
    ) dut_b (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (b_start),
        .i_running (b_running),
        .i_status  (b_status),
        .o_run     (b_run),
        .o_busy    (b_busy),
        .o_done    (b_done),
        .o_passed  (b_passed),
        .o_timeout (b_timeout),
        .o_cycles  (b_cycles)
    );

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_running(input bit b, input logic v);
        if (b) b_running = v;
        else a_running = v;
    endtask

    task automatic set_status(input bit b, input logic v);
        if (b) b_status = v;
        else a_status = v;
    endtask

    task automatic set_start(input bit b, input logic v);
        if (b) b_start = v;
        else a_start = v;
    endtask

    function automatic logic get_run(input bit b);
        return b ? b_run : a_run;
    endfunction

    function automatic logic get_done(input bit b);
        return b ? b_done : a_done;
    endfunction

    // Core stays stopped for pre edges, runs for hold edges, then halts.
    task automatic run_core(input bit b, input int pre, input int hold,
                            input logic status, input int pulse_at,
                            input int exp_cyc, input string nm);
        exp_t e;
        set_running(b, 1'b0);
        repeat (pre) tick();
        set_running(b, 1'b1);
        for (int i = 0; i < hold; i++) begin
            if (i == pulse_at) set_start(b, 1'b1);
            tick();
            set_start(b, 1'b0);
        end
        e.name    = nm;
        e.passed  = status;
        e.timeout = 1'b0;
        e.cycles  = exp_cyc;
        if (b) qb.push_back(e);
        else qa.push_back(e);
        set_running(b, 1'b0);
        set_status(b, status);
        tick();
        chk({nm, "_run_after_halt"}, get_run(b), 0);
        chk({nm, "_done_after_halt"}, get_done(b), 1);
    endtask

    task automatic restart(input bit b, input string nm);
        set_start(b, 1'b1);
        tick();
        set_start(b, 1'b0);
        chk({nm, "_run"}, get_run(b), 1);
        chk({nm, "_done"}, get_done(b), 0);
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(posedge a_done);
            #1;
            if (qa.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_unexpected_verdict: got done 1 expected none");
            end else begin
                e = qa.pop_front();
                chk({e.name, "_passed"}, a_passed, e.passed);
                chk({e.name, "_timeout"}, a_timeout, e.timeout);
                chk({e.name, "_cycles"}, a_cycles, e.cycles);
                chk({e.name, "_busy"}, a_busy, 0);
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(posedge b_done);
            #1;
            if (qb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_unexpected_verdict: got done 1 expected none");
            end else begin
                e = qb.pop_front();
                chk({e.name, "_passed"}, b_passed, e.passed);
                chk({e.name, "_timeout"}, b_timeout, e.timeout);
                chk({e.name, "_cycles"}, b_cycles, e.cycles);
                chk({e.name, "_busy"}, b_busy, 0);
            end
        end
    end

    initial begin : guard
        #100000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin : stim
        exp_t e;
        int   n;
        a_start = 0; a_running = 0; a_status = 0;
        b_start = 0; b_running = 0; b_status = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_run", a_run, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_passed", a_passed, 0);
        chk("rst_timeout", a_timeout, 0);
        chk("rst_cycles", a_cycles, 0);
        #9 rst_n = 1'b1;

        a_start = 1'b1;
        repeat (3) tick();
        a_start = 1'b0;
        chk("init_edge3_run", a_run, 0);
        tick();
        chk("init_edge4_run", a_run, 1);
        chk("init_edge4_busy", a_busy, 1);
        chk("init_edge4_cycles", a_cycles, 0);
        chk("b_idle_run", b_run, 0);

        run_core(0, 1, 11, 1'b1, -1, 12, "pass");

        a_running = 1'b1;
        repeat (2) tick();
        chk("done_glitch_run", a_run, 0);
        chk("done_glitch_done", a_done, 1);
        chk("done_glitch_cycles", a_cycles, 12);
        a_running = 1'b0;

        restart(0, "restart1");
        chk("restart1_cycles", a_cycles, 0);
        chk("restart1_passed", a_passed, 0);
        run_core(0, 2, 5, 1'b0, -1, 7, "fail");

        restart(0, "restart2");
        e.name = "wdog"; e.passed = 1'b0; e.timeout = 1'b1; e.cycles = 19;
        qa.push_back(e);
        n = 0;
        repeat (2) begin
            tick();
            n++;
        end
        a_running = 1'b1;
        while (!a_done && n < 60) begin
            tick();
            n++;
        end
        chk("wdog_edge", n, 20);
        chk("wdog_run", a_run, 0);
        a_running = 1'b0;
        restart(0, "restart3");
        chk("restart3_timeout", a_timeout, 0);
        chk("restart3_cycles", a_cycles, 0);

        run_core(0, 3, 16, 1'b1, 5, 19, "coincide");

        b_running = 1'b1;
        repeat (2) tick();
        chk("b_idle_glitch_run", b_run, 0);
        chk("b_idle_glitch_busy", b_busy, 0);
        b_running = 1'b0;
        restart(1, "b_start");
        run_core(1, 1, 29, 1'b1, -1, 15, "b_sat");

        restart(0, "restart4");
        a_running = 1'b1;
        repeat (4) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_run", a_run, 0);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_done", a_done, 0);
        chk("midrst_cycles", a_cycles, 0);
        chk("midrst_b_done", b_done, 0);
        a_running = 1'b0;
        #10 rst_n = 1'b1;
        repeat (3) tick();
        chk("rerst_edge3_run", a_run, 0);
        tick();
        chk("rerst_edge4_run", a_run, 1);

        repeat (2) tick();
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_supervisor.md
Name: cpu_supervisor

Overview:
Sequences the csm CPU core on the Fomu board and replaces the ad-hoc start-up delay and run gating currently done around the core.
- After reset, waits a fixed initialization delay, then raises the core's run request.
- Monitors the core's running/status outputs, enforces an optional watchdog cycle limit, and latches a pass/fail/timeout verdict for LEDs or a host.
- Supports restart from a start pulse without a board reset.

Parameters:
INIT_DELAY, 3, clock edges to wait after reset release before leaving INIT (device initialization)
TIMEOUT, 0, max cycles in START+RUN before forced stop; 0 disables the watchdog
CNT_W, 24, width of the cycle counter (saturating)
AUTO_START, 1, 1: leave INIT directly into START; 0: leave INIT into IDLE and wait for i_start

Ports:
i_clk  input  1  system clock; all state changes on the rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_start  input  1  one-cycle start/restart request (synchronous, already debounced)
i_running  input  1  core o_running
i_status  input  1  core o_status (1 = passed), valid when running falls
o_run  output  1  core i_run request, registered
o_busy  output  1  1 in START or RUN
o_done  output  1  verdict valid (state DONE)
o_passed  output  1  core halted with i_status=1
o_timeout  output  1  watchdog expired
o_cycles  output  CNT_W  cycles spent in START+RUN, frozen in DONE

Behaviour:
- Reset (asynchronous assert):
  - state=INIT, delay counter=INIT_DELAY.
  - All outputs 0, o_cycles=0.
  - Reset asserted mid-run drops o_run asynchronously; no verdict is produced.
- INIT:
  - Each edge: if delay==0, go to START (AUTO_START=1) or IDLE (AUTO_START=0); else delay--.
  - i_start is ignored.
  - o_run first reads 1 after exactly INIT_DELAY+1 edges following reset release.
- IDLE: o_run=0; on i_start go to START, clear o_cycles, o_passed, o_timeout.
- START:
  - o_run=1, o_busy=1.
  - Waits for i_running=1, then goes to RUN.
  - The cycle counter runs in START as well.
- RUN:
  - o_run=1; o_cycles increments every edge and saturates at 2^CNT_W-1 (no wrap).
  - Halt: i_running sampled 0 → next edge sets o_run=0, o_passed=i_status sampled on that same edge, o_done=1, state DONE. o_cycles does not count the halt edge.
  - Watchdog: TIMEOUT!=0 and o_cycles==TIMEOUT-1 at an edge → that edge sets o_run=0, o_timeout=1, o_passed=0, o_done=1, state DONE.
  - Simultaneous halt and timeout on the same edge: halt wins; report passed/failed, o_timeout=0.
- Watchdog in START: the same watchdog rule applies while waiting for i_running (covers a core that never starts).
- DONE:
  - Outputs hold; o_run=0.
  - On i_start, the next edge clears o_cycles, o_passed, o_timeout and o_done, and enters START; o_run=1 on that edge.
- i_start while in START or RUN: ignored; no restart, no counter clear.
- i_running glitch high while in IDLE or DONE: ignored.
- Outputs are decoded from registered state only: no combinational path from any input to any output.
- Encoding: 3-bit state. INIT=0, IDLE=1, START=2, RUN=3, DONE=4. Codes 5–7 recover to IDLE.

Decomposition:
- Shared include cpu_supervisor_defs.vh:
  - state encodings (localparams for INIT, IDLE, START, RUN, DONE);
  - verdict bit positions {timeout, passed, done} for LED mapping.
- One sub-module, sat_counter (parameter W; ports i_clk, i_rst_n, i_clr, i_en, o_count, o_max).
  - Used for o_cycles.
  - The INIT delay counter is an inline down-counter.

Test Plan:
- Power-up, INIT_DELAY=3, AUTO_START=1; core models i_running=1 two cycles after o_run, then drops it with i_status=1 after 10 cycles → o_run=1 at edge 4; o_passed=1, o_done=1, o_timeout=0; o_cycles=12 (START+RUN cycles).
- Same stimulus with i_status=0 at halt → o_done=1, o_passed=0, o_run=0 the edge after i_running falls.
- TIMEOUT=20, core never drops i_running → edge 20 after entering START sets o_timeout=1, o_run=0, o_cycles=19 frozen; the next i_start clears flags and o_run=1 again.
- Halt and watchdog coincide: TIMEOUT=20 with i_running falling so the halt edge equals the timeout edge → o_passed=i_status, o_timeout=0.
- AUTO_START=0: no o_run until i_start. i_start pulsed during RUN → no effect. CNT_W=4, run 30 cycles → o_cycles saturates at 15.
- Reset asserted mid-RUN (async, between edges) → o_run and all flags 0 immediately, state INIT; after release, the delay sequence repeats with o_run=1 at edge 4.
